care_menu: RTL and testbench

- Front-end input stage that turns three raw push-buttons (prev, next, select) into the 8-bit one-cycle care-action bus consumed by the stats block's inputs port.
- Synchronises and debounces each button, and keeps a wrapping menu cursor over the care actions.
- On select, fires a single-cycle pulse on the bit at the cursor position, then enforces a cooldown so the pet cannot be spam-fed.

---
 rtl/care_menu.sv | 176 +++++++++++++++++
 tb/tb_care_menu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/care_menu.sv
// care_menu: push-button front end for the pet care menu.
// Synchronises and debounces prev/next/select, keeps a wrapping cursor over
// NUM_ACTIONS care actions and fires a one-cycle one-hot action pulse on
// select, followed by a cooldown during which select is ignored.
// Optional build macro: CARE_MENU_AUTO_REPEAT_EN (auto-repeat of held prev/next).
module care_menu #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned COOLDOWN_CYCLES = 27000000,
  parameter int unsigned NUM_ACTIONS     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_prev,
  input  logic       btn_next,
  input  logic       btn_select,
  output logic [7:0] actions,
  output logic [2:0] cursor,
  output logic       busy
);

  localparam logic [19:0] DB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [26:0] CD_LAST  = 27'(COOLDOWN_CYCLES - 1);
  localparam logic [2:0]  CUR_LAST = 3'(NUM_ACTIONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    COOLDOWN
  } state_t;

  // Button vector order: [0] prev, [1] next, [2] select.
  logic [2:0]  raw;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  deb;
  logic [19:0] db_cnt [3];
  logic [2:0]  accept;
  logic [2:0]  press;
  logic        step_prev;
  logic        step_next;
  state_t      state;
  logic [26:0] cd_cnt;

  assign raw = {btn_select, btn_next, btn_prev};

  // Two-flop synchronisers for the asynchronous raw buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level once it has differed for DEBOUNCE_CYCLES; a press is
  // the accept of a rising level, so it lines up with the debounced edge.
  always_comb begin
    accept = '0;
    press  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      accept[i] = (sync2[i] != deb[i]) && (db_cnt[i] == DB_LAST);
      press[i]  = accept[i] & sync2[i];
    end
  end

  // Per-button debounce counters and debounced levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end

`ifdef CARE_MENU_AUTO_REPEAT_EN
  localparam logic [25:0] RPT_FIRST  = 26'(16 * DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] RPT_RELOAD = 26'(12 * DEBOUNCE_CYCLES);

  logic [25:0] rpt_cnt [2];
  logic [1:0]  rpt_step;

  // A repeat step fires when a held nav button's counter hits RPT_FIRST.
  always_comb begin
    rpt_step = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      rpt_step[i] = deb[i] && (rpt_cnt[i] == RPT_FIRST);
    end
  end

  // Reloading to 12*DEBOUNCE after a step spaces later steps 4*DEBOUNCE apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 2; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (!deb[i]) begin
          rpt_cnt[i] <= '0;
        end else if (rpt_step[i]) begin
          rpt_cnt[i] <= RPT_RELOAD;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + 26'd1;
        end
      end
    end
  end

  assign step_prev = press[0] | rpt_step[0];
  assign step_next = press[1] | rpt_step[1];
`else
  assign step_prev = press[0];
  assign step_next = press[1];
`endif

  // Wrapping cursor; simultaneous prev and next cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cursor <= '0;
    end else if (step_next && !step_prev) begin
      cursor <= (cursor == CUR_LAST) ? '0 : cursor + 3'd1;
    end else if (step_prev && !step_next) begin
      cursor <= (cursor == '0) ? CUR_LAST : cursor - 3'd1;
    end
  end

  // Action FSM: the pulse is registered on the IDLE->FIRE edge from the
  // pre-update cursor, so it is aligned with FIRE and strictly one-hot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cd_cnt  <= '0;
      actions <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press[2]) begin
            state   <= FIRE;
            actions <= 8'd1 << cursor;
            busy    <= 1'b1;
          end
        end
        FIRE: begin
          state   <= COOLDOWN;
          actions <= '0;
          cd_cnt  <= '0;
        end
        COOLDOWN: begin
          if (cd_cnt == CD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cd_cnt <= cd_cnt + 27'd1;
          end
        end
        default: begin
          state   <= IDLE;
          actions <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_care_menu.sv
// Directed bench for care_menu with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=10,
// NUM_ACTIONS=6. A debounced press lands 6 clock edges after the raw edge.
module tb_care_menu;

  logic       clk;
  logic       reset;
  logic       btn_prev;
  logic       btn_next;
  logic       btn_select;
  logic [7:0] actions;
  logic [2:0] cursor;
  logic       busy;

  int vectors;
  int miscompares;

  care_menu #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(10),
    .NUM_ACTIONS(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_prev(btn_prev),
    .btn_next(btn_next),
    .btn_select(btn_select),
    .actions(actions),
    .cursor(cursor),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold a raw button high 8 cycles (press accepted at the 6th edge), then
  // release for 8 cycles so its debounced level returns to 0.
  task automatic press_nav(input bit prev, input bit next);
    btn_prev = prev;
    btn_next = next;
    tick(8);
    btn_prev = 1'b0;
    btn_next = 1'b0;
    tick(8);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    btn_prev    = 1'b0;
    btn_next    = 1'b0;
    btn_select  = 1'b0;

    // Reset held while buttons toggle.
    for (int i = 0; i < 6; i++) begin
      btn_prev   = i[0];
      btn_next   = ~i[0];
      btn_select = i[1];
      tick(1);
    end
    chk("rst_actions", {24'd0, actions}, 32'h00);
    chk("rst_cursor", {29'd0, cursor}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    btn_prev   = 1'b0;
    btn_next   = 1'b0;
    btn_select = 1'b0;
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("idle_after_rst", {20'd0, actions, cursor, busy}, 32'd0);
    end

    // 3-cycle glitch on next is rejected.
    btn_next = 1'b1;
    tick(3);
    btn_next = 1'b0;
    tick(10);
    chk("glitch_cursor", {29'd0, cursor}, 32'd0);

    // Clean next press: cursor moves exactly 6 edges after the raw edge.
    btn_next = 1'b1;
    tick(5);
    chk("deb_lat_5", {29'd0, cursor}, 32'd0);
    tick(1);
    chk("deb_lat_6", {29'd0, cursor}, 32'd1);
    tick(100);
    chk("held_no_repeat", {29'd0, cursor}, 32'd1);
    btn_next = 1'b0;
    tick(10);
    chk("release_no_step", {29'd0, cursor}, 32'd1);

    // Wrap in both directions and simultaneous press.
    press_nav(1'b1, 1'b0);
    chk("prev_1_to_0", {29'd0, cursor}, 32'd0);
    press_nav(1'b1, 1'b0);
    chk("prev_wrap_5", {29'd0, cursor}, 32'd5);
    press_nav(1'b0, 1'b1);
    chk("next_wrap_0", {29'd0, cursor}, 32'd0);
    press_nav(1'b1, 1'b1);
    chk("both_unchanged", {29'd0, cursor}, 32'd0);
    press_nav(1'b0, 1'b1);
    press_nav(1'b0, 1'b1);
    press_nav(1'b0, 1'b1);
    chk("cursor_3", {29'd0, cursor}, 32'd3);

    // Fire at cursor 3. Raw select high after edge 0, low after edge 4.
    btn_select = 1'b1;
    tick(4);
    btn_select = 1'b0;
    tick(1);                                    // edge 5
    chk("pre_fire_actions", {24'd0, actions}, 32'h00);
    chk("pre_fire_busy", {31'd0, busy}, 32'd0);
    tick(1);                                    // edge 6: FIRE
    chk("fire_actions", {24'd0, actions}, 32'h08);
    chk("fire_busy", {31'd0, busy}, 32'd1);
    tick(1);                                    // edge 7
    chk("fire_one_cycle", {24'd0, actions}, 32'h00);
    chk("cd_busy_7", {31'd0, busy}, 32'd1);
    tick(1);                                    // edge 8
    chk("cd_busy_8", {31'd0, busy}, 32'd1);
    // Second select and a next press, both accepted at edge 14 (in cooldown).
    btn_select = 1'b1;
    btn_next   = 1'b1;
    for (int e = 9; e <= 16; e++) begin
      tick(1);
      chk("cd_busy", {31'd0, busy}, 32'd1);
      chk("cd_no_pulse", {24'd0, actions}, 32'h00);
      if (e == 13) chk("cd_cursor_13", {29'd0, cursor}, 32'd3);
      if (e == 14) chk("cd_nav_14", {29'd0, cursor}, 32'd4);
    end
    tick(1);                                    // edge 17: back to IDLE
    chk("busy_falls", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("not_queued", {23'd0, actions, busy}, 32'd0);
    end
    btn_select = 1'b0;
    btn_next   = 1'b0;
    tick(10);
    chk("cursor_4", {29'd0, cursor}, 32'd4);

    // Select after cooldown fires action 4.
    btn_select = 1'b1;
    tick(5);
    chk("pre_fire2", {24'd0, actions}, 32'h00);
    tick(1);
    chk("fire2_actions", {24'd0, actions}, 32'h10);
    btn_select = 1'b0;
    tick(3);
    chk("fire2_cd_busy", {31'd0, busy}, 32'd1);

    // Asynchronous reset during cooldown.
    reset = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_cursor", {29'd0, cursor}, 32'd0);
    chk("async_rst_actions", {24'd0, actions}, 32'h00);
    tick(3);
    reset = 1'b1;
    tick(2);
    chk("post_rst_idle", {23'd0, actions, busy}, 32'd0);

    // Fresh select fires action 0 with no leftover cooldown.
    btn_select = 1'b1;
    tick(5);
    chk("pre_fire3", {23'd0, actions, busy}, 32'd0);
    tick(1);
    chk("fire3_actions", {24'd0, actions}, 32'h01);
    chk("fire3_busy", {31'd0, busy}, 32'd1);
    tick(1);
    chk("fire3_one_cycle", {24'd0, actions}, 32'h00);
    btn_select = 1'b0;
    tick(20);
    chk("fire3_done", {23'd0, actions, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
